// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray-coded counter and its consumers.
//   DEFAULT_SIZE : default count width used by gray_counter
//   MAX_SIZE     : widest count the helper functions handle
//   bin2gray()   : binary -> reflected Gray code
//   gray2bin()   : reflected Gray code -> binary
// Both helpers work on MAX_SIZE-bit values; narrower counts are passed in
// zero-extended, which leaves the result correct in the low SIZE bits.
// ---------------------------------------------------------------------------
package gray_pkg;

  localparam int DEFAULT_SIZE = 8;
  localparam int MAX_SIZE     = 32;

  function automatic logic [MAX_SIZE-1:0] bin2gray(input logic [MAX_SIZE-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it, so walk
  // from the MSB down carrying the running parity.
  function automatic logic [MAX_SIZE-1:0] gray2bin(input logic [MAX_SIZE-1:0] g);
    logic [MAX_SIZE-1:0] b;
    b[MAX_SIZE-1] = g[MAX_SIZE-1];
    for (int i = MAX_SIZE - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// ---------------------------------------------------------------------------
// bin2gray_enc
// Combinational binary-to-Gray encoder.
//   bin  in  SIZE  binary value
//   gray out SIZE  bin ^ (bin >> 1)
// ---------------------------------------------------------------------------
module bin2gray_enc
  import gray_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic [SIZE-1:0] bin,
  output logic [SIZE-1:0] gray
);

  logic [MAX_SIZE-1:0] gray_wide;

  // Zero extension keeps the top Gray bit equal to the top binary bit.
  assign gray_wide = bin2gray(MAX_SIZE'(bin));
  assign gray      = gray_wide[SIZE-1:0];

endmodule

// File: rtl/gray_counter.sv
// ---------------------------------------------------------------------------
// gray_counter
// Registered up/down counter producing a binary count and its Gray code.
// Every output comes straight from a flop; gray and flags are computed from
// the next binary value so they always agree with bin.
//   clk      in  1     rising-edge clock
//   rst_n    in  1     asynchronous active-low reset
//   en       in  1     count enable, one step per cycle
//   up       in  1     1 = increment, 0 = decrement (used only when en=1)
//   load     in  1     synchronous load, wins over en
//   load_bin in  SIZE  value loaded into bin
//   gray     out SIZE  registered Gray count
//   bin      out SIZE  registered binary count
//   at_max   out 1     bin is all ones
//   at_min   out 1     bin is zero
//   wrapped  out 1     one-cycle pulse after crossing an end (WRAP=1 only)
// Parameters: SIZE (2..32), WRAP (1 = wrap, 0 = saturate).
// ---------------------------------------------------------------------------
module gray_counter
  import gray_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE,
  parameter bit WRAP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            up,
  input  logic            load,
  input  logic [SIZE-1:0] load_bin,
  output logic [SIZE-1:0] gray,
  output logic [SIZE-1:0] bin,
  output logic            at_max,
  output logic            at_min,
  output logic            wrapped
);

  // One extra bit on each side of the adder exposes carry/borrow, which is
  // exactly the "crossed an end of the range" indicator.
  logic [SIZE:0]   inc_ext;
  logic [SIZE:0]   dec_ext;
  logic [SIZE-1:0] bin_next;
  logic [SIZE-1:0] gray_next;
  logic            wrapped_next;

  assign inc_ext = {1'b0, bin} + {{SIZE{1'b0}}, 1'b1};
  assign dec_ext = {1'b0, bin} - {{SIZE{1'b0}}, 1'b1};

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    bin_next     = bin;
    wrapped_next = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (en) begin
      if (up) begin
        // In saturate mode a carry means "already at the top": hold.
        if (!inc_ext[SIZE] || WRAP) bin_next = inc_ext[SIZE-1:0];
        wrapped_next = inc_ext[SIZE] & WRAP;
      end else begin
        if (!dec_ext[SIZE] || WRAP) bin_next = dec_ext[SIZE-1:0];
        wrapped_next = dec_ext[SIZE] & WRAP;
      end
    end
  end

  bin2gray_enc #(
    .SIZE (SIZE)
  ) u_enc (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // NOTE: every flop here is control/status state, so all of them take the
  // asynchronous reset; at_min resets high because bin resets to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin     <= '0;
      gray    <= '0;
      at_max  <= 1'b0;
      at_min  <= 1'b1;
      wrapped <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      bin     <= bin_next;
      gray    <= gray_next;
      at_max  <= &bin_next;
      at_min  <= ~|bin_next;
      wrapped <= wrapped_next;
    end
  end

endmodule
